// File: rtl/grostl_nonce_scheduler.sv
// Nonce sequencer for the pipelined Grostl-512 core: issues one nonce per cycle,
// tracks each through the core latency and reports hashes at or below target.
module grostl_nonce_scheduler #(
  parameter int HASH_LATENCY = 86
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [607:0] block,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [63:0]  target,
  output logic [607:0] core_block,
  output logic [31:0]  core_nonce,
  input  logic [511:0] core_hash,
  output logic         busy,
  output logic         done,
  output logic         found_valid,
  output logic [31:0]  found_nonce,
  input  logic         found_ready,
  output logic         overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                  state, state_nxt;
  logic [31:0]             nonce_end_q;
  logic [31:0]             ret;
  logic [63:0]             target_q;
  logic [HASH_LATENCY-1:0] vld_sr;
  logic                    start_ok, abort_ok, drain_done;
  logic                    tail, hit, hash_low_unused;

  assign tail = vld_sr[HASH_LATENCY-1];
  // The core emits words swapped, so the most significant hash word is on top.
  assign hit  = tail && (core_hash[511:448] <= target_q);
  assign hash_low_unused = ^core_hash[447:0];

  // NOTE: every variable gets a default before the case, so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    start_ok   = 1'b0;
    abort_ok   = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        start_ok  = 1'b1;
      end
      RUN: if (abort) begin
        state_nxt = IDLE;
        abort_ok  = 1'b1;
      end else if (core_nonce == nonce_end_q) begin
        state_nxt = DRAIN;
      end
      DRAIN: if (abort) begin
        state_nxt = IDLE;
        abort_ok  = 1'b1;
      end else if (vld_sr[HASH_LATENCY-2:0] == '0) begin
        // The tail holds the last in-flight nonce; it retires this cycle.
        state_nxt  = IDLE;
        drain_done = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      core_block  <= '0;
      core_nonce  <= '0;
      nonce_end_q <= '0;
      target_q    <= '0;
      ret         <= '0;
      vld_sr      <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= drain_done;
      if (start_ok) begin
        core_block  <= block;
        core_nonce  <= nonce_start;
        nonce_end_q <= nonce_end;
        target_q    <= target;
      end else if (state == RUN && state_nxt == RUN) begin
        core_nonce <= core_nonce + 32'd1;
      end
      if (start_ok)  ret <= nonce_start;
      else if (tail) ret <= ret + 32'd1;
      if (abort_ok) vld_sr <= '0;
      else          vld_sr <= {vld_sr[HASH_LATENCY-2:0], state == RUN};
    end
  end

  // Result holding register; a pending result outlives job end and abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      found_valid <= 1'b0;
      found_nonce <= '0;
      overflow    <= 1'b0;
    end else if (start_ok) begin
      found_valid <= 1'b0;
      overflow    <= 1'b0;
    end else if (hit) begin
      if (!found_valid || found_ready) begin
        found_valid <= 1'b1;
        found_nonce <= ret;
      end else begin
        overflow <= 1'b1;
      end
    end else if (found_valid && found_ready) begin
      found_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_grostl_nonce_scheduler.sv
// Self-checking bench for grostl_nonce_scheduler: a fixed-latency core model plus
// a job-level reference that predicts every cycle from the nonce schedule.
module tb_grostl_nonce_scheduler;
  localparam int L = 86;

  logic         clk = 1'b0;
  logic         reset, start, abort, found_ready;
  logic [607:0] block;
  logic [31:0]  nonce_start, nonce_end;
  logic [63:0]  target;
  logic [607:0] core_block;
  logic [31:0]  core_nonce;
  logic [511:0] core_hash;
  logic         busy, done, found_valid, overflow;
  logic [31:0]  found_nonce;

  int n_checks = 0;
  int n_fail   = 0;

  int first_fv, done_at, ov_at, fv_rises;
  logic [31:0] got[$];

  bit          rand_mode = 1'b0;
  logic [31:0] seed = 32'd0;
  bit          hit_set[bit [31:0]];

  always #5 clk = ~clk;

  grostl_nonce_scheduler #(.HASH_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .block(block),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .core_block(core_block), .core_nonce(core_nonce), .core_hash(core_hash),
    .busy(busy), .done(done), .found_valid(found_valid), .found_nonce(found_nonce),
    .found_ready(found_ready), .overflow(overflow)
  );

  function automatic logic [31:0] mix(input logic [31:0] x);
    logic [31:0] y = x;
    y ^= y >> 16;
    y = y * 32'h7feb352d;
    y ^= y >> 15;
    y = y * 32'h846ca68b;
    y ^= y >> 16;
    return y;
  endfunction

  // Top hash word the core model produces for a nonce.
  function automatic logic [63:0] upper_of(input logic [31:0] n);
    if (rand_mode) return {mix(n ^ seed), mix(n + seed + 32'h9e3779b9)};
    if (hit_set.exists(n)) return 64'd0;
    return {64{1'b1}};
  endfunction

  // Core model: the hash of the nonce seen in cycle c is presented in cycle c+L.
  logic [31:0] dl [L-1] = '{default: 32'd0};
  always @(posedge clk) begin
    dl[0] <= core_nonce;
    for (int i = 1; i < L - 1; i++) dl[i] <= dl[i-1];
    core_hash <= {upper_of(dl[L-2]), {14{dl[L-2]}}};
  end

  task automatic launch(input logic [31:0] ns, input logic [31:0] ne,
                        input logic [63:0] tg, output logic [607:0] blk);
    @(negedge clk);
    for (int i = 0; i < 19; i++) blk[i*32 +: 32] = $urandom;
    block = blk; nonce_start = ns; nonce_end = ne; target = tg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one job and predicts every output cycle by cycle from the nonce schedule.
  task automatic run_job(input logic [31:0] ns, input logic [31:0] ne,
                         input logic [63:0] tg, input int rmode, input int extra);
    logic [31:0]  span, exp_fn;
    logic [607:0] blk;
    logic         exp_fv, exp_ov, exp_busy, exp_done, hit, prev_fv;
    int           n, last, idx;
    span = ne - ns;
    n    = int'(span) + 1;
    last = n + L + 1 + extra;
    got.delete();
    first_fv = -1; done_at = -1; ov_at = -1; fv_rises = 0;
    exp_fv = 1'b0; exp_ov = 1'b0; exp_fn = '0; prev_fv = 1'b0;
    launch(ns, ne, tg, blk);
    n_checks++;
    if (core_block !== blk) begin
      n_fail++; $display("FAIL core_block: got %h, expected %h", core_block[63:0], blk[63:0]);
    end
    for (int m = 1; m <= last; m++) begin
      exp_busy = (m <= n + L);
      exp_done = (m == n + L + 1);
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++; $display("FAIL busy @%0d: got %b, expected %b", m, busy, exp_busy);
      end
      n_checks++;
      if (done !== exp_done) begin
        n_fail++; $display("FAIL done @%0d: got %b, expected %b", m, done, exp_done);
      end
      n_checks++;
      if (found_valid !== exp_fv) begin
        n_fail++; $display("FAIL found_valid @%0d: got %b, expected %b", m, found_valid, exp_fv);
      end
      if (exp_fv) begin
        n_checks++;
        if (found_nonce !== exp_fn) begin
          n_fail++; $display("FAIL found_nonce @%0d: got %h, expected %h", m, found_nonce, exp_fn);
        end
      end
      n_checks++;
      if (overflow !== exp_ov) begin
        n_fail++; $display("FAIL overflow @%0d: got %b, expected %b", m, overflow, exp_ov);
      end
      if (m <= n) begin
        n_checks++;
        if (core_nonce !== ns + 32'(m - 1)) begin
          n_fail++; $display("FAIL core_nonce @%0d: got %h, expected %h", m, core_nonce, ns + 32'(m - 1));
        end
      end
      if (found_valid === 1'b1 && !prev_fv) begin
        fv_rises++;
        if (first_fv < 0) first_fv = m;
      end
      prev_fv = (found_valid === 1'b1);
      if (done === 1'b1 && done_at < 0) done_at = m;
      if (overflow === 1'b1 && ov_at < 0) ov_at = m;
      case (rmode)
        0:       found_ready = 1'b0;
        1:       found_ready = 1'b1;
        default: found_ready = 1'($urandom_range(0, 1));
      endcase
      if (found_valid === 1'b1 && found_ready) got.push_back(found_nonce);
      idx = m - 1 - L;
      hit = (idx >= 0) && (idx < n) && (upper_of(ns + 32'(idx)) <= tg);
      if (hit) begin
        if (!exp_fv || found_ready) begin
          exp_fv = 1'b1;
          exp_fn = ns + 32'(idx);
        end else begin
          exp_ov = 1'b1;
        end
      end else if (exp_fv && found_ready) begin
        exp_fv = 1'b0;
      end
      if (m < last) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [607:0] blk;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, found_valid, overflow} !== 4'b0) begin
      n_fail++; $display("FAIL reset flags: got %b, expected 0000", {busy, done, found_valid, overflow});
    end
    n_checks++;
    if (core_nonce !== 32'd0 || found_nonce !== 32'd0) begin
      n_fail++; $display("FAIL reset nonces: got %h/%h, expected 0/0", core_nonce, found_nonce);
    end
    n_checks++;
    if (core_block !== '0) begin
      n_fail++; $display("FAIL reset core_block: got %h, expected 0", core_block[63:0]);
    end
    reset = 1'b0;
    hit_set.delete();
    rand_mode = 1'b0;
    launch(32'h10, 32'h30, 64'd0, blk);
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL midrun busy: got %b, expected 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, found_valid, overflow} !== 4'b0 || core_nonce !== 32'd0 || core_block !== '0) begin
      n_fail++; $display("FAIL async reset: got flags %b nonce %h, expected 0",
                         {busy, done, found_valid, overflow}, core_nonce);
    end
    @(negedge clk);
    reset = 1'b0;
    run_job(32'h7, 32'h7, {64{1'b1}}, 1, 2);
    n_checks++;
    if (got.size() != 1 || got[0] !== 32'h7) begin
      n_fail++; $display("FAIL post-reset result: got %0d results, expected one of 00000007", got.size());
    end
  endtask

  task automatic test_basic();
    hit_set.delete();
    hit_set[32'h105] = 1'b1;
    rand_mode = 1'b0;
    run_job(32'h100, 32'h10F, 64'd0, 0, 2);
    n_checks++;
    if (first_fv != L + 7) begin
      n_fail++; $display("FAIL basic hit time: got %0d, expected %0d", first_fv, L + 7);
    end
    n_checks++;
    if (done_at != 16 + L + 1) begin
      n_fail++; $display("FAIL basic done time: got %0d, expected %0d", done_at, 16 + L + 1);
    end
    n_checks++;
    if (fv_rises != 1 || found_nonce !== 32'h105) begin
      n_fail++; $display("FAIL basic result: got %0d hits nonce %h, expected 1 hit 105", fv_rises, found_nonce);
    end
    found_ready = 1'b1;
    @(negedge clk);
    found_ready = 1'b0;
    n_checks++;
    if (found_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic accept: got found_valid %b, expected 0", found_valid);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w [4];
    exp_w = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
    hit_set.delete();
    rand_mode = 1'b0;
    run_job(32'hFFFFFFFE, 32'h1, {64{1'b1}}, 1, 2);
    n_checks++;
    if (got.size() != 4) begin
      n_fail++; $display("FAIL wrap count: got %0d, expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got[i] !== exp_w[i]) begin
          n_fail++; $display("FAIL wrap result %0d: got %h, expected %h", i, got[i], exp_w[i]);
        end
      end
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL wrap overflow: got %b, expected 0", overflow);
    end
  endtask

  task automatic test_back_pressure();
    hit_set.delete();
    hit_set[32'h203] = 1'b1;
    hit_set[32'h204] = 1'b1;
    hit_set[32'h205] = 1'b1;
    rand_mode = 1'b0;
    run_job(32'h200, 32'h20F, 64'd0, 0, 2);
    n_checks++;
    if (first_fv != L + 5 || ov_at != L + 6) begin
      n_fail++; $display("FAIL bp timing: got hit %0d overflow %0d, expected %0d %0d",
                         first_fv, ov_at, L + 5, L + 6);
    end
    n_checks++;
    if (found_nonce !== 32'h203 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL bp hold: got %h ov %b, expected 203 ov 1", found_nonce, overflow);
    end
    found_ready = 1'b1;
    @(negedge clk);
    found_ready = 1'b0;
    n_checks++;
    if (found_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL bp accept: got fv %b ov %b, expected 0 1", found_valid, overflow);
    end
  endtask

  task automatic test_abort();
    logic [607:0] blk;
    hit_set.delete();
    hit_set[32'h1000 + 32'd20] = 1'b1;
    rand_mode = 1'b0;
    found_ready = 1'b0;
    launch(32'h1000, 32'h1000 + 32'd999, 64'd0, blk);
    for (int m = 1; m <= L + 40; m++) begin
      if (m == 1) begin
        n_checks++;
        if (overflow !== 1'b0) begin
          n_fail++; $display("FAIL start clears overflow: got %b, expected 0", overflow);
        end
      end
      if (m <= 10) begin
        n_checks++;
        if (busy !== 1'b1 || core_nonce !== 32'h1000 + 32'(m - 1)) begin
          n_fail++; $display("FAIL abort run @%0d: got busy %b nonce %h, expected 1 %h",
                             m, busy, core_nonce, 32'h1000 + 32'(m - 1));
        end
      end else begin
        n_checks++;
        if ({busy, found_valid, done} !== 3'b000) begin
          n_fail++; $display("FAIL after abort @%0d: got busy/fv/done %b, expected 000",
                             m, {busy, found_valid, done});
        end
      end
      if (m == 5) begin
        start = 1'b1;
        nonce_start = 32'hDEAD0000;
      end
      if (m == 6)  start = 1'b0;
      if (m == 10) abort = 1'b1;
      if (m == 11) abort = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    hit_set.delete();
    hit_set[32'h42] = 1'b1;
    rand_mode = 1'b0;
    run_job(32'h42, 32'h42, 64'd0, 1, 2);
    n_checks++;
    if (done_at != L + 2 || first_fv != L + 2) begin
      n_fail++; $display("FAIL single timing: got done %0d hit %0d, expected %0d", done_at, first_fv, L + 2);
    end
    n_checks++;
    if (got.size() != 1 || got[0] !== 32'h42) begin
      n_fail++; $display("FAIL single result: got %0d results, expected one of 00000042", got.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] ns;
    int n;
    rand_mode = 1'b1;
    for (int j = 0; j < 6; j++) begin
      seed = $urandom;
      ns   = (j % 2 == 1) ? 32'($urandom) : 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      n    = $urandom_range(1, 24);
      run_job(ns, ns + 32'(n - 1), {32'($urandom), 32'($urandom)}, 2, 2);
    end
  endtask

  task automatic test_back_to_back();
    rand_mode = 1'b1;
    seed = $urandom;
    run_job(32'h5000, 32'h5007, {32'($urandom), 32'($urandom)}, 2, 0);
    run_job(32'h6000, 32'h6003, {32'($urandom), 32'($urandom)}, 1, 2);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; found_ready = 1'b0;
    block = '0; nonce_start = '0; nonce_end = '0; target = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_pressure();
    test_abort();
    test_single();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
